// File: rtl/uart_spi_bridge.sv
// uart_spi_bridge
//   Takes one UART byte on i_rx, exchanges it with a single SPI peripheral
//   (mode 0, MSB first), and returns the byte read from i_cipo as a UART
//   frame on o_tx. It handles one byte in and one byte out per transaction.
//   The default frame format is 8N1.
//   Build macro UART_PARITY_EN: both UART directions then carry an even
//   parity bit after bit7 (8E1). An RX parity mismatch is handled like a
//   framing error.
//
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised rx line
//   RX    | sampling start, data, [parity], stop bits at mid-bit
//   SPI   | eight SCLK pulses, shifting the RX byte out and the reply in
//   TX    | sending the reply frame, aligned to the free-running baud tick
module uart_spi_bridge #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int SCLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_tx,
  input  logic i_cipo,
  output logic o_copi,
  output logic o_sclk,
  output logic o_ready,
  output logic o_error
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int BW        = $clog2(BIT_CLKS + 1);
  localparam int SW        = $clog2(SCLK_DIV + 1);

  localparam logic [BW-1:0] BIT_RELOAD  = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(HALF_CLKS - 1);
  localparam logic [BW-1:0] BW_ZERO     = '0;
  localparam logic [SW-1:0] SCLK_RELOAD = SW'(SCLK_DIV - 1);
  localparam logic [SW-1:0] SW_ZERO     = '0;

`ifdef UART_PARITY_EN
  // rx bit index of the stop bit: 0 = start, 1..8 = data, 9 = parity
  localparam logic [3:0] RX_STOP_IDX = 4'd10;
  // bits following the start bit: 8 data + parity + stop
  localparam int         TX_SH_W     = 10;
`else
  // rx bit index of the stop bit: 0 = start, 1..8 = data
  localparam logic [3:0] RX_STOP_IDX = 4'd9;
  // bits following the start bit: 8 data + stop
  localparam int         TX_SH_W     = 9;
`endif
  localparam logic [3:0] TX_LAST = 4'(TX_SH_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RX   = 2'd1;
  localparam logic [1:0] S_SPI  = 2'd2;
  localparam logic [1:0] S_TX   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_sync_q, rx_sync_d;
  logic               rx_prev_q, rx_prev_d;
  logic [BW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]         rx_idx_q, rx_idx_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
`ifdef UART_PARITY_EN
  logic               rx_par_q, rx_par_d;
`endif
  logic [SW-1:0]      spi_cnt_q, spi_cnt_d;
  logic [3:0]         spi_bits_q, spi_bits_d;
  logic [7:0]         spi_sh_q, spi_sh_d;
  logic               sclk_q, sclk_d;
  logic               copi_q, copi_d;
  logic [TX_SH_W-1:0] tx_sh_q, tx_sh_d;
  logic [3:0]         tx_left_q, tx_left_d;
  logic               tx_busy_q, tx_busy_d;
  logic               tx_q, tx_d;
  logic               error_q, error_d;

  logic               baud_tick;
  logic               rx_fall;
  logic               frame_ok;

  assign baud_tick = (baud_cnt_q == BW_ZERO);
  assign rx_fall   = rx_prev_q & ~rx_sync_q;

`ifdef UART_PARITY_EN
  assign frame_ok = rx_sync_q & ~(^{rx_sh_q, rx_par_q});
`else
  assign frame_ok = rx_sync_q;
`endif

  // Next-state logic: synchroniser, baud generator and the bridge FSM
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = i_rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    baud_cnt_d = baud_tick ? BIT_RELOAD : baud_cnt_q - BW'(1);
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    spi_cnt_d  = spi_cnt_q;
    spi_bits_d = spi_bits_q;
    spi_sh_d   = spi_sh_q;
    sclk_d     = sclk_q;
    copi_d     = copi_q;
    tx_sh_d    = tx_sh_q;
    tx_left_d  = tx_left_q;
    tx_busy_d  = tx_busy_q;
    tx_d       = tx_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d  = S_RX;
          rx_cnt_d = HALF_RELOAD;
          rx_idx_d = 4'd0;
        end
      end

      S_RX: begin
        if (rx_cnt_q != BW_ZERO) begin
          rx_cnt_d = rx_cnt_q - BW'(1);
        end else begin
          rx_cnt_d = BIT_RELOAD;
          rx_idx_d = rx_idx_q + 4'd1;
          if (rx_idx_q == 4'd0) begin
            // line back high at mid start bit: treat as a glitch
            if (rx_sync_q) begin
              state_d = S_IDLE;
            end
          end else if (rx_idx_q == RX_STOP_IDX) begin
            if (frame_ok) begin
              state_d    = S_SPI;
              spi_sh_d   = rx_sh_q;
              copi_d     = rx_sh_q[7];
              sclk_d     = 1'b0;
              spi_cnt_d  = SCLK_RELOAD;
              spi_bits_d = 4'd0;
            end else begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          end else if (rx_idx_q <= 4'd8) begin
            rx_sh_d = {rx_sync_q, rx_sh_q[7:1]};
          end else begin
`ifdef UART_PARITY_EN
            rx_par_d = rx_sync_q;
`endif
          end
        end
      end

      S_SPI: begin
        if (spi_cnt_q != SW_ZERO) begin
          spi_cnt_d = spi_cnt_q - SW'(1);
        end else begin
          spi_cnt_d = SCLK_RELOAD;
          if (!sclk_q) begin
            // rising edge: capture the peripheral bit on the LSB side
            sclk_d     = 1'b1;
            spi_sh_d   = {spi_sh_q[6:0], i_cipo};
            spi_bits_d = spi_bits_q + 4'd1;
          end else begin
            sclk_d = 1'b0;
            if (spi_bits_q == 4'd8) begin
              copi_d    = 1'b0;
              tx_busy_d = 1'b0;
              state_d   = S_TX;
            end else begin
              copi_d = spi_sh_q[7];
            end
          end
        end
      end

      S_TX: begin
        if (baud_tick) begin
          if (!tx_busy_q) begin
            tx_d      = 1'b0;
`ifdef UART_PARITY_EN
            tx_sh_d   = {1'b1, ^spi_sh_q, spi_sh_q};
`else
            tx_sh_d   = {1'b1, spi_sh_q};
`endif
            tx_left_d = TX_LAST;
            tx_busy_d = 1'b1;
          end else if (tx_left_q == 4'd0) begin
            // stop bit has been held for a full period
            tx_d      = 1'b1;
            tx_busy_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            tx_d      = tx_sh_q[0];
            tx_sh_d   = {1'b0, tx_sh_q[TX_SH_W-1:1]};
            tx_left_d = tx_left_q - 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transfer and parks the lines idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      baud_cnt_q <= '0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
      spi_cnt_q  <= '0;
      spi_bits_q <= '0;
      spi_sh_q   <= '0;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      tx_sh_q    <= '0;
      tx_left_q  <= '0;
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      baud_cnt_q <= baud_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
      spi_cnt_q  <= spi_cnt_d;
      spi_bits_q <= spi_bits_d;
      spi_sh_q   <= spi_sh_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      tx_sh_q    <= tx_sh_d;
      tx_left_q  <= tx_left_d;
      tx_busy_q  <= tx_busy_d;
      tx_q       <= tx_d;
      error_q    <= error_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_copi  = copi_q;
  assign o_sclk  = sclk_q;
  assign o_ready = (state_q == S_IDLE);
  assign o_error = error_q;

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Directed bench for uart_spi_bridge with a short bit period (16 clocks)
// and SCLK_DIV = 3. The SPI peripheral is modelled by a pattern that
// advances on each SCLK fall. Define UART_PARITY_EN to exercise 8E1 frames.
module tb_uart_spi_bridge;

  localparam int BIT_CLKS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx;
  logic cipo;
  logic copi;
  logic sclk;
  logic ready;
  logic error;

  int tests = 0;
  int fails = 0;

  // monitors: monotonic counters and a log of copi at each sclk rise
  int         sclk_rises = 0;
  int         sclk_falls = 0;
  int         tx_low_cnt = 0;
  logic [7:0] copi_log   = 8'h00;

  // peripheral model: presents cipo_pat MSB first, next bit after each fall
  logic [7:0] cipo_pat  = 8'h00;
  int         fall_base = 0;
  logic [2:0] pidx;
  assign pidx = 3'(7 - (sclk_falls - fall_base));
  assign cipo = cipo_pat[pidx];

  uart_spi_bridge #(
    .CLK_HZ  (1_600_000),
    .BAUD    (100_000),
    .SCLK_DIV(3)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_rx   (rx),
    .o_tx   (tx),
    .i_cipo (cipo),
    .o_copi (copi),
    .o_sclk (sclk),
    .o_ready(ready),
    .o_error(error)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    sclk_rises <= sclk_rises + 1;
    copi_log   <= {copi_log[6:0], copi};
  end

  always @(negedge sclk) sclk_falls <= sclk_falls + 1;

  always @(negedge clk) if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bit_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d);
    rx = 1'b0;
    bit_wait(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait(BIT_CLKS);
    end
  endtask

  // frame with correct parity (when enabled) and the given stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(d);
`ifdef UART_PARITY_EN
    rx = ^d;
    bit_wait(BIT_CLKS);
`endif
    rx = stop;
    bit_wait(BIT_CLKS);
    rx = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bits(d);
    rx = par;
    bit_wait(BIT_CLKS);
    rx = 1'b1;
    bit_wait(BIT_CLKS);
  endtask
`endif

  // receive one reply frame from o_tx; ok drops on timeout or bad framing
  task automatic recv_frame(output logic [7:0] d, output logic ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    d = 8'h00;
    while (tx !== 1'b0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
    end else begin
      bit_wait(BIT_CLKS / 2);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bit_wait(BIT_CLKS);
        d[i] = tx;
      end
`ifdef UART_PARITY_EN
      bit_wait(BIT_CLKS);
      if (tx !== ^d) ok = 1'b0;
`endif
      bit_wait(BIT_CLKS);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got;
    logic       ok;
    int         rise_base;
    int         low_base;
    int         guard;

    // 1. reset held 25 clocks
    rst_n = 1'b0;
    bit_wait(25);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_copi", copi, 1'b0);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_error", error, 1'b0);
    bit_wait(5);

    // 2. 0xB5 out over SPI, peripheral answers 0x3B
    cipo_pat  = 8'h3B;
    fall_base = sclk_falls;
    rise_base = sclk_rises;
    send_frame(8'hB5, 1'b1);
    chk1("busy_ready", ready, 1'b0);
    recv_frame(got, ok);
    chk1("b5_tx_frame", ok, 1'b1);
    chk8("b5_tx_byte", got, 8'h3B);
    chk8("b5_copi_bits", copi_log, 8'hB5);
    chki("b5_sclk_pulses", sclk_rises - rise_base, 8);
    bit_wait(BIT_CLKS);
    chk1("b5_done_ready", ready, 1'b1);
    chk1("b5_done_sclk", sclk, 1'b0);
    chk1("b5_done_copi", copi, 1'b0);
    chk1("b5_done_tx", tx, 1'b1);

    // 3. framing error, then a good frame with the error still latched
    rise_base = sclk_rises;
    low_base  = tx_low_cnt;
    send_frame(8'h00, 1'b0);
    bit_wait(4 * BIT_CLKS);
    chk1("ferr_error", error, 1'b1);
    chki("ferr_sclk_pulses", sclk_rises - rise_base, 0);
    chki("ferr_tx_low", tx_low_cnt - low_base, 0);
    chk1("ferr_ready", ready, 1'b1);

    cipo_pat  = 8'hC3;
    fall_base = sclk_falls;
    rise_base = sclk_rises;
    send_frame(8'h5A, 1'b1);
    recv_frame(got, ok);
    chk1("5a_tx_frame", ok, 1'b1);
    chk8("5a_tx_byte", got, 8'hC3);
    chk8("5a_copi_bits", copi_log, 8'h5A);
    chki("5a_sclk_pulses", sclk_rises - rise_base, 8);
    chk1("5a_error_sticky", error, 1'b1);
    bit_wait(BIT_CLKS);

    // 4. half-bit glitch in IDLE is a false start
    rise_base = sclk_rises;
    low_base  = tx_low_cnt;
    rx = 1'b0;
    bit_wait(BIT_CLKS / 2);
    rx = 1'b1;
    chk1("glitch_seen_ready", ready, 1'b0);
    bit_wait(3 * BIT_CLKS);
    chk1("glitch_ready", ready, 1'b1);
    chki("glitch_sclk_pulses", sclk_rises - rise_base, 0);
    chki("glitch_tx_low", tx_low_cnt - low_base, 0);

    // 5. reset during SPI bit 4, then a clean 0xFF round trip
    cipo_pat  = 8'h00;
    fall_base = sclk_falls;
    rise_base = sclk_rises;
    send_frame(8'hF0, 1'b1);
    guard = 0;
    while ((sclk_rises - rise_base) < 4 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk1("pre_rst_sclk", sclk, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_sclk", sclk, 1'b0);
    chk1("mid_rst_copi", copi, 1'b0);
    chk1("mid_rst_ready", ready, 1'b1);
    chk1("mid_rst_error", error, 1'b0);
    bit_wait(3);
    rst_n = 1'b1;
    bit_wait(3);

    cipo_pat  = 8'hFF;
    fall_base = sclk_falls;
    rise_base = sclk_rises;
    send_frame(8'hFF, 1'b1);
    recv_frame(got, ok);
    chk1("ff_tx_frame", ok, 1'b1);
    chk8("ff_tx_byte", got, 8'hFF);
    chk8("ff_copi_bits", copi_log, 8'hFF);
    chki("ff_sclk_pulses", sclk_rises - rise_base, 8);
    bit_wait(BIT_CLKS);

`ifdef UART_PARITY_EN
    // 6. parity: 0x01 needs parity bit 1
    rise_base = sclk_rises;
    send_frame_par(8'h01, 1'b0);
    bit_wait(3 * BIT_CLKS);
    chk1("par_bad_error", error, 1'b1);
    chki("par_bad_sclk_pulses", sclk_rises - rise_base, 0);

    cipo_pat  = 8'h80;
    fall_base = sclk_falls;
    rise_base = sclk_rises;
    send_frame_par(8'h01, 1'b1);
    recv_frame(got, ok);
    chk1("par_ok_tx_frame", ok, 1'b1);
    chk8("par_ok_tx_byte", got, 8'h80);
    chk8("par_ok_copi_bits", copi_log, 8'h01);
    chki("par_ok_sclk_pulses", sclk_rises - rise_base, 8);
    bit_wait(BIT_CLKS);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
